seg_shift_tx: RTL and testbench



---
 rtl/seg_shift_pkg.sv | 6 +
 rtl/seg_shift_phase.sv | 31 +++
 rtl/seg_shift_tx.sv | 85 ++++++++
 tb/tb_seg_shift_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seg_shift_pkg.sv
// seg_shift_pkg: shared state type and default sizing for the serial display shifter.
package seg_shift_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} seg_shift_state_t;
  localparam int SEG_SHIFT_WIDTH = 64;
  localparam int SEG_SHIFT_DIV = 4;
endpackage

// File: rtl/seg_shift_phase.sv
// seg_shift_phase: per-bit phase counter producing the registered serial clock level.
module seg_shift_phase #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sclk_lvl,
  output logic bit_end
);
  localparam int PW = $clog2(2 * DIV);
  localparam logic [PW-1:0] LAST = PW'(2 * DIV - 1);
  localparam logic [PW-1:0] HI = PW'(DIV);
  logic [PW-1:0] phase_q, phase_d;
  logic sclk_d;
  always_comb begin
    phase_d = (!en || clr || phase_q == LAST) ? '0 : phase_q + 1'b1;
    sclk_d = !en || phase_d >= HI;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      sclk_lvl <= 1'b1;
    end else begin
      phase_q <= phase_d;
      sclk_lvl <= sclk_d;
    end
  end
  assign bit_end = phase_q == LAST;
endmodule

// File: rtl/seg_shift_tx.sv
// seg_shift_tx: MSB-first serial frame transmitter for a chained shift-register display.
// Define SEG_SHIFT_PEN_BLANK_EN to blank pen while a frame is shifting.
module seg_shift_tx
  import seg_shift_pkg::*;
#(
  parameter int WIDTH = SEG_SHIFT_WIDTH,
  parameter int DIV = SEG_SHIFT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sout,
  output logic             pen,
  output logic             clrn
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  seg_shift_state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic busy_q, done_q, sout_q, clrn_q, bit_end, accept;
  assign accept = state_q == IDLE && start;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    bitcnt_d = bitcnt_q;
    if (accept) begin
      state_d = SHIFT;
      sr_d = din;
      bitcnt_d = '0;
    end else if (state_q == SHIFT && bit_end) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
      bitcnt_d = bitcnt_q + 1'b1;
      state_d = bitcnt_q == LAST_BIT ? DONE : SHIFT;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      bitcnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sout_q <= 1'b0;
      clrn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      bitcnt_q <= bitcnt_d;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
      sout_q <= state_d == SHIFT && sr_d[WIDTH-1];
      clrn_q <= 1'b1;
    end
  end
  // Enable tracks the next state so sclk drops in the first SHIFT cycle.
  seg_shift_phase #(.DIV(DIV)) u_phase (
    .clk(clk),
    .rst(rst),
    .en(state_d == SHIFT),
    .clr(accept),
    .sclk_lvl(sclk),
    .bit_end(bit_end)
  );
`ifdef SEG_SHIFT_PEN_BLANK_EN
  logic pen_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pen_q <= 1'b1;
    else pen_q <= state_d != SHIFT;
  end
  assign pen = pen_q;
`else
  assign pen = 1'b1;
`endif
  assign busy = busy_q;
  assign done = done_q;
  assign sout = sout_q;
  assign clrn = clrn_q;
endmodule

// File: tb/tb_seg_shift_tx.sv
// tb_seg_shift_tx: scoreboard bench; u0 runs WIDTH=8/DIV=2, u1 runs WIDTH=8/DIV=1.
module tb_seg_shift_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [7:0] din0 = '0, din1 = '0;
  logic busy0, done0, sclk0, sout0, pen0, clrn0;
  logic busy1, done1, sclk1, sout1, pen1, clrn1;
  int cyc = 0, tests = 0, fails = 0, a = 0;
  typedef struct {logic [7:0] data; int done_cyc;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  logic prev0 = 1'b1, prev1 = 1'b1;
  logic [7:0] cap0 = '0, cap1 = '0;
  int ne0 = 0, ne1 = 0;
`ifdef SEG_SHIFT_PEN_BLANK_EN
  localparam logic PEN_SHIFT = 1'b0;
`else
  localparam logic PEN_SHIFT = 1'b1;
`endif

  seg_shift_tx #(.WIDTH(8), .DIV(2)) u0 (
    .clk(clk), .rst(rst), .start(start0), .din(din0), .busy(busy0), .done(done0),
    .sclk(sclk0), .sout(sout0), .pen(pen0), .clrn(clrn0)
  );
  seg_shift_tx #(.WIDTH(8), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1), .busy(busy1), .done(done1),
    .sclk(sclk1), .sout(sout1), .pen(pen1), .clrn(clrn1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cap0 = '0;
      ne0 = 0;
    end else begin
      if (sclk0 && !prev0) begin
        cap0 = {cap0[6:0], sout0};
        ne0++;
      end
      if (done0) begin
        if (q0.size() == 0) chk("u0 unexpected done", cyc, -1);
        else begin
          e0 = q0.pop_front();
          chk("u0 frame data", cap0, e0.data);
          chk("u0 rising edges", ne0, 8);
          chk("u0 done cycle", cyc, e0.done_cyc);
        end
        cap0 = '0;
        ne0 = 0;
      end
    end
    prev0 = sclk0;
  end

  always @(negedge clk) begin
    if (rst) begin
      cap1 = '0;
      ne1 = 0;
    end else begin
      if (sclk1 && !prev1) begin
        cap1 = {cap1[6:0], sout1};
        ne1++;
      end
      if (done1) begin
        if (q1.size() == 0) chk("u1 unexpected done", cyc, -1);
        else begin
          e1 = q1.pop_front();
          chk("u1 frame data", cap1, e1.data);
          chk("u1 rising edges", ne1, 8);
          chk("u1 done cycle", cyc, e1.done_cyc);
        end
        cap1 = '0;
        ne1 = 0;
      end
    end
    prev1 = sclk1;
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (busy0 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send0(input logic [7:0] d, output int acc);
    @(negedge clk);
    din0 = d;
    start0 = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst sclk", sclk0, 1);
    chk("rst sout", sout0, 0);
    chk("rst pen", pen0, 1);
    chk("rst clrn", clrn0, 0);
    chk("rst busy", busy0, 0);
    rst = 1'b0;
    #1 chk("clrn before edge", clrn0, 0);
    @(negedge clk);
    chk("clrn after edge", clrn0, 1);
    // single frame A5, DIV=2
    send0(8'hA5, a);
    q0.push_back('{8'hA5, a + 32});
    chk("busy cycle 1", busy0, 1);
    wait_idle0();
    chk("busy drop cycle", cyc, a + 33);
    // DIV=1 frame 01
    @(negedge clk);
    din1 = 8'h01;
    start1 = 1'b1;
    @(posedge clk);
    #1 a = cyc;
    q1.push_back('{8'h01, a + 16});
    @(negedge clk);
    start1 = 1'b0;
    chk("u1 sclk low cycle 1", sclk1, 0);
    @(negedge clk);
    chk("u1 sclk high cycle 2", sclk1, 1);
    wait_cyc(a + 17);
    chk("u1 idle cycle 18", busy1, 0);
    // ignored starts during SHIFT and DONE
    send0(8'hFF, a);
    q0.push_back('{8'hFF, a + 32});
    wait_cyc(a + 4);
    din0 = 8'h00;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("pen during shift", pen0, PEN_SHIFT);
    wait_cyc(a + 32);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("busy after ignored start", busy0, 0);
    repeat (3) @(negedge clk);
    chk("still idle", busy0, 0);
    // continuous start
    @(negedge clk);
    din0 = 8'h3C;
    start0 = 1'b1;
    @(posedge clk);
    #1 a = cyc;
    q0.push_back('{8'h3C, a + 32});
    q0.push_back('{8'h3C, a + 66});
    q0.push_back('{8'h3C, a + 100});
    wait_cyc(a + 100);
    start0 = 1'b0;
    @(negedge clk);
    chk("continuous stop idle", busy0, 0);
    // abort mid-frame with reset
    send0(8'hC3, a);
    wait_cyc(a + 4);
    chk("abort pen cycle 5", pen0, PEN_SHIFT);
    wait_cyc(a + 9);
    rst = 1'b1;
    #1;
    chk("abort sclk", sclk0, 1);
    chk("abort sout", sout0, 0);
    chk("abort busy", busy0, 0);
    chk("abort done", done0, 0);
    chk("abort clrn", clrn0, 0);
    chk("abort pen", pen0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort clrn back", clrn0, 1);
    repeat (40) @(negedge clk);
    chk("abort stays idle", busy0, 0);
    chk("u0 queue empty", q0.size(), 0);
    chk("u1 queue empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
